// File: rtl/gen_sram_init.sv
// gen_sram_init: simple-dual-port SRAM with byte-strobed writes, a hardware
// clear of the whole array after reset, a read-valid flag, a selectable
// 1- or 2-cycle read latency and a selectable read-during-write behaviour.
//
// Ports:
//   CLK         clock, all logic on posedge
//   RSTn        synchronous active-low reset (array contents are not reset)
//   data_w      write data
//   addr_w      write address
//   data_wstrb  byte write enables, bit i covers data_w[8*i+7:8*i]
//   en_w        write request
//   addr_r      read address
//   en_r        read request
//   data_r      read data, holds its last value between results
//   data_r_vld  data_r carries the result of a request issued RD_LAT cycles ago
//   init_done   array clear complete, write/read ports are accepted
//
// State table:
//   state    | meaning
//   ST_CLEAR | writing INIT_VAL to ram[clr_addr], ports ignored
//   ST_READY | normal operation, init_done high

module gen_sram_init #(
    parameter int          DW       = 32,
    parameter int          AW       = 14,
    parameter int          RD_LAT   = 1,
    parameter int          RDW_MODE = 1,
    parameter int          INIT_EN  = 1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [DW-1:0]         data_w,
    input  logic [AW-1:0]         addr_w,
    input  logic [(DW+7)/8-1:0]   data_wstrb,
    input  logic                  en_w,
    input  logic [AW-1:0]         addr_r,
    input  logic                  en_r,
    output logic [DW-1:0]         data_r,
    output logic                  data_r_vld,
    output logic                  init_done
);

    localparam int DP = 2**AW;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t          state;
    logic [AW-1:0]   clr_addr;

    logic [DW-1:0]   ram [DP];

    logic [DW-1:0]   wmask;
    logic [DW-1:0]   rd_raw;
    logic [DW-1:0]   rd_merged;
    logic            clr_we;
    logic            usr_we;
    logic            rd_en;

    logic [DW-1:0]   rd1_data;
    logic            rd1_vld;
    logic [DW-1:0]   rd2_data;
    logic            rd2_vld;

    // Byte strobes expanded to a per-bit mask; the partial top byte of a
    // non-multiple-of-8 width simply has no bits above DW to touch.
    always_comb begin
        wmask = '0;
        for (int b = 0; b < DW; b++) begin
            wmask[b] = data_wstrb[b/8];
        end
    end

    assign clr_we = RSTn && (state == ST_CLEAR);
    assign usr_we = RSTn && (state == ST_READY) && en_w;
    assign rd_en  = (state == ST_READY) && en_r;
    assign rd_raw = ram[addr_r];

    // Write-first forwarding only for strobed bytes of a same-address write.
    always_comb begin
        rd_merged = rd_raw;
        if ((RDW_MODE == 1) && usr_we && (addr_w == addr_r)) begin
            rd_merged = (rd_raw & ~wmask) | (data_w & wmask);
        end
    end

    always_ff @(posedge CLK) begin
        if (clr_we) begin
            ram[clr_addr] <= INIT_VAL;
        end else if (usr_we) begin
            for (int b = 0; b < DW; b++) begin
                if (wmask[b]) begin
                    ram[addr_w][b] <= data_w[b];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state     <= (INIT_EN != 0) ? ST_CLEAR : ST_READY;
            clr_addr  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    // Exit on the last word instead of letting clr_addr wrap.
                    if (clr_addr == {AW{1'b1}}) begin
                        state     <= ST_READY;
                        init_done <= 1'b1;
                    end else begin
                        clr_addr  <= clr_addr + 1'b1;
                    end
                end
                ST_READY: begin
                    init_done <= 1'b1;
                end
                default: begin
                    state <= ST_READY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            rd1_data <= '0;
            rd1_vld  <= 1'b0;
            rd2_data <= '0;
            rd2_vld  <= 1'b0;
        end else begin
            rd1_vld <= rd_en;
            if (rd_en) begin
                rd1_data <= rd_merged;
            end
            rd2_vld <= rd1_vld;
            if (rd1_vld) begin
                rd2_data <= rd1_data;
            end
        end
    end

    assign data_r     = (RD_LAT == 2) ? rd2_data : rd1_data;
    assign data_r_vld = (RD_LAT == 2) ? rd2_vld  : rd1_vld;

endmodule

// File: tb/tb_gen_sram_init.sv
// Directed bench for gen_sram_init. Four instances share one clock, reset and
// stimulus: u_a (RD_LAT=1, write-first), u_b (old-data read-during-write),
// u_c (RD_LAT=2) and u_d (DW=12, no clear).

module tb_gen_sram_init;

    logic        clk;
    logic        rstn;
    logic [31:0] data_w;
    logic [3:0]  addr_w;
    logic [3:0]  strb;
    logic        en_w;
    logic [3:0]  addr_r;
    logic        en_r;

    logic [31:0] dr_a, dr_b, dr_c;
    logic [11:0] dr_d;
    logic        vld_a, vld_b, vld_c, vld_d;
    logic        done_a, done_b, done_c, done_d;

    int n_tests = 0;
    int n_fail  = 0;

    gen_sram_init #(.DW(32), .AW(4), .RD_LAT(1), .RDW_MODE(1), .INIT_EN(1),
                    .INIT_VAL(32'hA5A5A5A5)) u_a (
        .CLK(clk), .RSTn(rstn), .data_w(data_w), .addr_w(addr_w),
        .data_wstrb(strb), .en_w(en_w), .addr_r(addr_r), .en_r(en_r),
        .data_r(dr_a), .data_r_vld(vld_a), .init_done(done_a));

    gen_sram_init #(.DW(32), .AW(4), .RD_LAT(1), .RDW_MODE(0), .INIT_EN(1),
                    .INIT_VAL(32'hA5A5A5A5)) u_b (
        .CLK(clk), .RSTn(rstn), .data_w(data_w), .addr_w(addr_w),
        .data_wstrb(strb), .en_w(en_w), .addr_r(addr_r), .en_r(en_r),
        .data_r(dr_b), .data_r_vld(vld_b), .init_done(done_b));

    gen_sram_init #(.DW(32), .AW(4), .RD_LAT(2), .RDW_MODE(1), .INIT_EN(1),
                    .INIT_VAL(32'hA5A5A5A5)) u_c (
        .CLK(clk), .RSTn(rstn), .data_w(data_w), .addr_w(addr_w),
        .data_wstrb(strb), .en_w(en_w), .addr_r(addr_r), .en_r(en_r),
        .data_r(dr_c), .data_r_vld(vld_c), .init_done(done_c));

    gen_sram_init #(.DW(12), .AW(4), .RD_LAT(1), .RDW_MODE(1), .INIT_EN(0),
                    .INIT_VAL(12'h000)) u_d (
        .CLK(clk), .RSTn(rstn), .data_w(data_w[11:0]), .addr_w(addr_w),
        .data_wstrb(strb[1:0]), .en_w(en_w), .addr_r(addr_r), .en_r(en_r),
        .data_r(dr_d), .data_r_vld(vld_d), .init_done(done_d));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        en_w = 1'b1; addr_w = a; data_w = d; strb = s;
        tick();
        en_w = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; en_w = 1'b0; en_r = 1'b0;
        data_w = '0; addr_w = '0; addr_r = '0; strb = '0;
        tick(); tick(); tick();
        n_tests++;
        if (done_a !== 1'b0 || vld_a !== 1'b0 || dr_a !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_a: done=%b vld=%b data=%h, want 0 0 00000000", done_a, vld_a, dr_a);
        end
        n_tests++;
        if (done_d !== 1'b0 || vld_c !== 1'b0 || dr_c !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cd: done_d=%b vld_c=%b data_c=%h, want 0 0 00000000", done_d, vld_c, dr_c);
        end
        rstn = 1'b1;
        en_r = 1'b1;   // must be ignored throughout the clear
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 1) begin
                n_tests++;
                if (done_d !== 1'b1) begin
                    n_fail++;
                    $display("FAIL noinit_done: got %b after first edge, want 1", done_d);
                end
            end
            n_tests++;
            if (done_a !== (k == 16)) begin
                n_fail++;
                $display("FAIL init_done_rise: cycle %0d got %b want %b", k, done_a, (k == 16));
            end
            n_tests++;
            if (vld_a !== 1'b0 || vld_c !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_no_vld: cycle %0d vld_a=%b vld_c=%b want 0", k, vld_a, vld_c);
            end
        end
        en_r = 1'b0;
    endtask

    task automatic test_clear_read();
        for (int a = 0; a < 16; a++) begin
            en_r = 1'b1; addr_r = 4'(a);
            tick();
            n_tests++;
            if (vld_a !== 1'b1 || dr_a !== 32'hA5A5A5A5) begin
                n_fail++;
                $display("FAIL clear_read: addr %0d vld=%b data=%h want 1 a5a5a5a5", a, vld_a, dr_a);
            end
        end
        en_r = 1'b0;
        tick();
        n_tests++;
        if (vld_a !== 1'b0 || dr_a !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL idle_hold: vld=%b data=%h want 0 a5a5a5a5", vld_a, dr_a);
        end
    endtask

    task automatic test_strobe_write();
        do_write(4'd3, 32'h11223344, 4'b0101);
        en_r = 1'b1; addr_r = 4'd3;
        tick();
        en_r = 1'b0;
        n_tests++;
        if (vld_a !== 1'b1 || dr_a !== 32'hA522A544) begin
            n_fail++;
            $display("FAIL strobe_write: vld=%b data=%h want 1 a522a544", vld_a, dr_a);
        end
    endtask

    task automatic test_rdw();
        en_w = 1'b1; addr_w = 4'd5; data_w = 32'hDEADBEEF; strb = 4'b1100;
        en_r = 1'b1; addr_r = 4'd5;
        tick();
        en_w = 1'b0;
        n_tests++;
        if (dr_a !== 32'hDEADA5A5) begin
            n_fail++;
            $display("FAIL rdw_write_first: got %h want deada5a5", dr_a);
        end
        n_tests++;
        if (dr_b !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL rdw_old_data: got %h want a5a5a5a5", dr_b);
        end
        tick();
        n_tests++;
        if (dr_a !== 32'hDEADA5A5 || dr_b !== 32'hDEADA5A5) begin
            n_fail++;
            $display("FAIL rdw_after: a=%h b=%h want deada5a5", dr_a, dr_b);
        end
        en_w = 1'b1; addr_w = 4'd6; data_w = 32'h00000000; strb = 4'b1111;
        addr_r = 4'd7;
        tick();
        en_w = 1'b0; en_r = 1'b0;
        n_tests++;
        if (dr_a !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL rdw_diff_addr: got %h want a5a5a5a5", dr_a);
        end
    endtask

    task automatic test_pipeline();
        do_write(4'd0, 32'h00001111, 4'b1111);
        do_write(4'd1, 32'h22223333, 4'b1111);
        do_write(4'd2, 32'h44445555, 4'b1111);
        en_r = 1'b1; addr_r = 4'd0;
        tick();                                   // edge N
        n_tests++;
        if (vld_c !== 1'b0 || vld_a !== 1'b1 || dr_a !== 32'h00001111) begin
            n_fail++;
            $display("FAIL lat2_first: vld_c=%b vld_a=%b dr_a=%h want 0 1 00001111", vld_c, vld_a, dr_a);
        end
        addr_r = 4'd1;
        tick();
        n_tests++;
        if (vld_c !== 1'b1 || dr_c !== 32'h00001111) begin
            n_fail++;
            $display("FAIL lat2_r0: vld=%b data=%h want 1 00001111", vld_c, dr_c);
        end
        addr_r = 4'd2;
        tick();
        en_r = 1'b0;
        n_tests++;
        if (vld_c !== 1'b1 || dr_c !== 32'h22223333) begin
            n_fail++;
            $display("FAIL lat2_r1: vld=%b data=%h want 1 22223333", vld_c, dr_c);
        end
        tick();
        n_tests++;
        if (vld_c !== 1'b1 || dr_c !== 32'h44445555) begin
            n_fail++;
            $display("FAIL lat2_r2: vld=%b data=%h want 1 44445555", vld_c, dr_c);
        end
        tick();
        n_tests++;
        if (vld_c !== 1'b0 || dr_c !== 32'h44445555) begin
            n_fail++;
            $display("FAIL lat2_hold: vld=%b data=%h want 0 44445555", vld_c, dr_c);
        end
    endtask

    task automatic test_dw12();
        do_write(4'd7, 32'h000000AB, 4'b0011);
        do_write(4'd7, 32'h00000FFF, 4'b0010);
        en_r = 1'b1; addr_r = 4'd7;
        tick();
        en_r = 1'b0;
        n_tests++;
        if (vld_d !== 1'b1 || dr_d !== 12'hFAB) begin
            n_fail++;
            $display("FAIL dw12_strobe: vld=%b data=%h want 1 fab", vld_d, dr_d);
        end
        n_tests++;
        if (dr_a !== 32'hA5A50FAB) begin
            n_fail++;
            $display("FAIL dw32_strobe: got %h want a5a50fab", dr_a);
        end
    endtask

    task automatic test_reset_mid_clear();
        en_r = 1'b1; addr_r = 4'd0;
        tick();
        en_r = 1'b0; rstn = 1'b0;
        tick();
        n_tests++;
        if (vld_c !== 1'b0 || vld_a !== 1'b0 || dr_a !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_drops_vld: vld_c=%b vld_a=%b dr_a=%h want 0 0 00000000", vld_c, vld_a, dr_a);
        end
        rstn = 1'b1;
        for (int k = 0; k < 9; k++) tick();       // clr_addr now 9
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k == 11) begin
                en_w = 1'b1; addr_w = 4'd2; data_w = 32'h12345678; strb = 4'b1111;
            end else begin
                en_w = 1'b0;
            end
            tick();
            n_tests++;
            if (done_a !== (k == 16)) begin
                n_fail++;
                $display("FAIL restart_done: cycle %0d got %b want %b", k, done_a, (k == 16));
            end
        end
        en_w = 1'b0;
        en_r = 1'b1; addr_r = 4'd2;
        tick();
        n_tests++;
        if (vld_a !== 1'b1 || dr_a !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL clear_ignores_w: vld=%b data=%h want 1 a5a5a5a5", vld_a, dr_a);
        end
        addr_r = 4'd3;
        tick();
        en_r = 1'b0;
        n_tests++;
        if (dr_a !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL reclear_addr3: got %h want a5a5a5a5", dr_a);
        end
    endtask

    initial begin
        test_reset();
        test_clear_read();
        test_strobe_write();
        test_rdw();
        test_pipeline();
        test_dw12();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
